// File: rtl/page_switcher.sv
// page_switcher: selects the active page, muxes its output, gates user input, resets entered pages.
// Define PAGE_EDGE_EN to deliver rising edges of user_in (sampled on tick) instead of levels.
module page_switcher #(
  parameter int NUM_PAGES  = 4,
  parameter int IN_W       = 16,
  parameter int OUT_W      = 32,
  parameter int PID_W      = $clog2(NUM_PAGES),
  parameter int RST_CYCLES = 2,
  parameter int INIT_PAGE  = 0
) (
  input  logic                       clk,
  input  logic                       sys_rst_n,
  input  logic                       tick,
  input  logic [IN_W-1:0]            user_in,
  input  logic [NUM_PAGES*OUT_W-1:0] page_out,
  input  logic [NUM_PAGES*PID_W-1:0] page_req,
  output logic [OUT_W-1:0]           prog_out,
  output logic [NUM_PAGES*IN_W-1:0]  page_in,
  output logic [NUM_PAGES-1:0]       page_rst,
  output logic [PID_W-1:0]           cur_page,
  output logic                       switching,
  output logic                       bad_req,
  output logic [7:0]                 switch_cnt
);
  typedef enum logic {RUN, SWITCH} state_t;
  localparam logic [7:0]       RC = 8'(RST_CYCLES);
  localparam logic [PID_W-1:0] IP = PID_W'(INIT_PAGE);
  state_t           state_q;
  logic [PID_W-1:0] cur_page_q, target_q, r;
  logic [7:0]       rcnt_q, switch_cnt_q;
  logic             bad_req_q;
  logic [IN_W-1:0]  in_v;
  logic [OUT_W-1:0] out_w [NUM_PAGES];
  logic [PID_W-1:0] req_w [NUM_PAGES];
  assign r = req_w[cur_page_q];
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= SWITCH;
      cur_page_q   <= IP;
      target_q     <= IP;
      rcnt_q       <= RC;
      bad_req_q    <= 1'b0;
      switch_cnt_q <= 8'd0;
    end else if (tick) begin
      if (state_q == RUN) begin
        if (r == cur_page_q) begin
        end else if (32'(r) >= NUM_PAGES) bad_req_q <= 1'b1;
        else begin
          target_q <= r;
          rcnt_q   <= RC;
          state_q  <= SWITCH;
        end
      end else if (rcnt_q > 8'd1) rcnt_q <= rcnt_q - 8'd1;
      else begin
        cur_page_q   <= target_q;
        state_q      <= RUN;
        switch_cnt_q <= switch_cnt_q + 8'd1;
      end
    end
  end
`ifdef PAGE_EDGE_EN
  logic [IN_W-1:0] prev_q;
  // Sampling on every tick also covers the completing switch tick, so held keys give no edge.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) prev_q <= '0;
    else if (tick) prev_q <= user_in;
  end
  assign in_v = user_in & ~prev_q;
`else
  assign in_v = user_in;
`endif
  for (genvar p = 0; p < NUM_PAGES; p++) begin : g_p
    assign out_w[p] = page_out[p*OUT_W +: OUT_W];
    assign req_w[p] = page_req[p*PID_W +: PID_W];
    assign page_rst[p] = state_q == SWITCH && target_q == PID_W'(p);
    assign page_in[p*IN_W +: IN_W] = (state_q == RUN && cur_page_q == PID_W'(p)) ? in_v : '0;
  end
  assign prog_out   = state_q == RUN ? out_w[cur_page_q] : '0;
  assign switching  = state_q == SWITCH;
  assign cur_page   = cur_page_q;
  assign bad_req    = bad_req_q;
  assign switch_cnt = switch_cnt_q;
endmodule

// File: doc/page_switcher.md
Name: page_switcher

Overview:
- Parametrised top-level page controller. It generalises the fixed INIT/MENU/HISTORY/PLAY dispatch to NUM_PAGES pages.
- Selects the active page and muxes that page's output bus to the unified output handler.
- Gates user input so only the active page sees it.
- Issues a multi-tick reset to the page being entered. All decisions advance on the program-clock enable tick.

Parameters:
- NUM_PAGES, 4, number of pages, 2..16
- IN_W, 16, width of one unified user-input word
- OUT_W, 32, width of one page output word
- PID_W, $clog2(NUM_PAGES), page-id width (derived)
- RST_CYCLES, 2, ticks that page_rst is held on entry, 1..255
- INIT_PAGE, 0, page entered after reset

Ports:
- clk  in  1  system clock
- sys_rst_n  in  1  asynchronous active-low reset
- tick  in  1  program-clock enable, 1-cycle pulse
- user_in  in  IN_W  unified user input
- page_out  in  NUM_PAGES*OUT_W  per-page output words; slice p is page p
- page_req  in  NUM_PAGES*PID_W  per-page requested next page id
- prog_out  out  OUT_W  output word of the active page
- page_in  out  NUM_PAGES*IN_W  per-page gated input
- page_rst  out  NUM_PAGES  per-page synchronous reset
- cur_page  out  PID_W  active page id
- switching  out  1  high while a page switch is in progress
- bad_req  out  1  sticky flag: an out-of-range request was seen
- switch_cnt  out  8  completed switches, wraps 255->0

Behaviour:
- FSM states: RUN, SWITCH. Registers: state, cur_page, target, rcnt (8b), bad_req, switch_cnt.
- Reset (async assert, sync release):
  - state=SWITCH, target=INIT_PAGE, cur_page=INIT_PAGE, rcnt=RST_CYCLES.
  - bad_req=0, switch_cnt=0.
  - The INIT page is therefore reset for RST_CYCLES ticks after release.
- RUN, on tick: r = page_req slice of cur_page.
  - r == cur_page: stay in RUN.
  - r >= NUM_PAGES: stay in RUN; bad_req<=1.
  - Otherwise: target<=r, rcnt<=RST_CYCLES, state<=SWITCH.
- RUN, no tick: all registers hold.
- SWITCH, on tick:
  - If rcnt>1: rcnt<=rcnt-1.
  - If rcnt==1: cur_page<=target, state<=RUN, switch_cnt<=switch_cnt+1.
  - The post-reset entry also counts, so switch_cnt=1 after the init sequence.
- page_req is ignored throughout SWITCH. Requests are never queued.
- Combinational outputs:
  - page_rst[p] = (state==SWITCH && p==target).
  - switching = (state==SWITCH).
  - prog_out = page_out slice of cur_page in RUN; all-zero in SWITCH (blank output during the switch).
  - page_in slice p = user_in when state==RUN and p==cur_page; zero otherwise.
- Timing:
  - Switch latency: exactly RST_CYCLES ticks from the SWITCH entry tick to the first RUN tick.
  - The new page's output is visible the clk cycle after the last reset tick.
- Events with no tick do not change state. tick is sampled on every clk edge.
- Reset mid-SWITCH aborts the switch and restarts at INIT_PAGE.
- Unused page-id codes (NUM_PAGES not a power of 2) are never entered.

Optional Feature:
- Macro: PAGE_EDGE_EN.
- Defined:
  - page_in carries rising edges of user_in, i.e. user_in & ~prev.
  - prev updates only on tick; each bit is a one-tick pulse while the active page is in RUN.
  - On the tick that completes a switch, prev<=user_in, so keys held across a switch produce no edge.
  - prev resets to 0.
- Undefined: page_in carries the level user_in. No prev register exists.

Test Plan:
- Release reset, tick every 4 clk -> switching=1 and page_rst[0]=1 for 2 ticks; then cur_page=0, switching=0, switch_cnt=1, prog_out=page_out[0].
- In RUN on page 0, set page_req[0]=2 -> page_rst[2]=1 for ticks 1-2 and prog_out=0; then cur_page=2, switch_cnt=2, page_in[2]=user_in, page_in[0]=0.
- On page 2, set page_req[2]=2 and page_out[2]=32'hA5A5_0001 -> no switch; prog_out=32'hA5A5_0001 and stable.
- NUM_PAGES=3, page_req[0]=3 -> cur_page stays 0; bad_req=1 and stays set after page_req returns to 0.
- During SWITCH toward page 1, page_req[0]=3 and page_req[1]=2 -> ignored; lands on page 1; bad_req=0. Then assert sys_rst_n=0 mid-SWITCH toward page 2 -> outputs reset immediately; re-entry at page 0.
- PAGE_EDGE_EN defined, user_in bit 3 held from before the switch to page 1 -> no pulse on page_in[1]; release then press -> page_in[1][3]=1 for exactly one tick.
